// File: rtl/ladybug_input_cond.sv
// Lady Bug input conditioning: debounces the raw control levels, reduces each joystick
// to one 4-way direction, and turns coins into fixed pulses followed by a lockout.
module ladybug_input_cond #(
  parameter int DEB_CYCLES = 65536,
  parameter int COIN_LEN   = 2000000,
  parameter int COIN_GAP   = 4000000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [1:0] in_coin,
  input  logic [1:0] in_start,
  input  logic [1:0] in_fire,
  input  logic [1:0] in_bomb,
  input  logic       in_tilt,
  input  logic [1:0] in_up,
  input  logic [1:0] in_down,
  input  logic [1:0] in_left,
  input  logic [1:0] in_right,
  output logic [1:0] but_coin_s,
  output logic [1:0] but_select_s,
  output logic [1:0] but_fire_s,
  output logic [1:0] but_bomb_s,
  output logic [1:0] but_tilt_s,
  output logic [1:0] but_up_s,
  output logic [1:0] but_down_s,
  output logic [1:0] but_left_s,
  output logic [1:0] but_right_s
);

  localparam int NB = 17;
  localparam int DW = $clog2(DEB_CYCLES) + 1;
  localparam int CW = (($clog2(COIN_LEN) > $clog2(COIN_GAP)) ?
                       $clog2(COIN_LEN) : $clog2(COIN_GAP)) + 1;

  typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
  typedef enum logic [1:0] {C_IDLE, C_PULSE, C_GAP} coin_t;

  // Bit map: coin[1:0] start[3:2] fire[5:4] bomb[7:6] up[9:8] down[11:10]
  // left[13:12] right[15:14] tilt[16].
  logic [NB-1:0] raw;
  logic [NB-1:0] stable_q;
  logic [DW-1:0] deb_cnt_q [NB];

  assign raw = {in_tilt, in_right, in_left, in_down, in_up, in_bomb, in_fire, in_start, in_coin};

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      stable_q <= '0;
      for (int i = 0; i < NB; i++) deb_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (raw[i] == stable_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
          stable_q[i]  <= raw[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Edge detection on debounced coin and direction bits; held vectors are {up,down,left,right}.
  logic [1:0] coin_prev_q, coin_rise;
  logic [3:0] dir_held [2];
  logic [3:0] dir_prev_q [2];
  logic [3:0] dir_rise [2];

  assign coin_rise = stable_q[1:0] & ~coin_prev_q;

  for (genvar p = 0; p < 2; p++) begin : g_dir
    assign dir_held[p] = {stable_q[8+p], stable_q[10+p], stable_q[12+p], stable_q[14+p]};
    assign dir_rise[p] = dir_held[p] & ~dir_prev_q[p];
  end

  function automatic dir_t pick(input logic [3:0] v);
    if (v[3])      return DIR_UP;
    else if (v[2]) return DIR_DOWN;
    else if (v[1]) return DIR_LEFT;
    else if (v[0]) return DIR_RIGHT;
    else           return DIR_NONE;
  endfunction

  function automatic logic is_held(input dir_t d, input logic [3:0] v);
    case (d)
      DIR_UP:    return v[3];
      DIR_DOWN:  return v[2];
      DIR_LEFT:  return v[1];
      DIR_RIGHT: return v[0];
      default:   return 1'b0;
    endcase
  endfunction

  dir_t          dir_q [2];
  dir_t          dir_d [2];
  coin_t         coin_state_q [2];
  coin_t         coin_state_d [2];
  logic [CW-1:0] coin_cnt_q [2];
  logic [CW-1:0] coin_cnt_d [2];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      coin_prev_q <= '0;
      for (int p = 0; p < 2; p++) begin
        dir_prev_q[p]   <= '0;
        dir_q[p]        <= DIR_NONE;
        coin_state_q[p] <= C_IDLE;
        coin_cnt_q[p]   <= '0;
      end
    end else begin
      coin_prev_q <= stable_q[1:0];
      for (int p = 0; p < 2; p++) begin
        dir_prev_q[p]   <= dir_held[p];
        dir_q[p]        <= dir_d[p];
        coin_state_q[p] <= coin_state_d[p];
        coin_cnt_q[p]   <= coin_cnt_d[p];
      end
    end
  end

  // A fresh press always wins; a falling selection falls back to whatever is still held.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      dir_d[p] = dir_q[p];
      if (|dir_rise[p]) begin
        dir_d[p] = pick(dir_rise[p]);
      end else if (dir_q[p] != DIR_NONE && !is_held(dir_q[p], dir_held[p])) begin
        dir_d[p] = pick(dir_held[p]);
      end
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      coin_state_d[p] = coin_state_q[p];
      coin_cnt_d[p]   = coin_cnt_q[p];
      case (coin_state_q[p])
        C_IDLE: begin
          if (coin_rise[p]) begin
            coin_state_d[p] = C_PULSE;
            coin_cnt_d[p]   = '0;
          end
        end
        C_PULSE: begin
          if (coin_cnt_q[p] == CW'(COIN_LEN - 1)) begin
            coin_state_d[p] = C_GAP;
            coin_cnt_d[p]   = '0;
          end else begin
            coin_cnt_d[p] = coin_cnt_q[p] + CW'(1);
          end
        end
        C_GAP: begin
          if (coin_cnt_q[p] == CW'(COIN_GAP - 1)) begin
            coin_state_d[p] = C_IDLE;
            coin_cnt_d[p]   = '0;
          end else begin
            coin_cnt_d[p] = coin_cnt_q[p] + CW'(1);
          end
        end
        default: begin
          coin_state_d[p] = C_IDLE;
          coin_cnt_d[p]   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from next-state so they move on the same edge as the FSMs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      but_coin_s   <= 2'b11;
      but_select_s <= 2'b11;
      but_fire_s   <= 2'b11;
      but_bomb_s   <= 2'b11;
      but_tilt_s   <= 2'b11;
      but_up_s     <= 2'b11;
      but_down_s   <= 2'b11;
      but_left_s   <= 2'b11;
      but_right_s  <= 2'b11;
    end else begin
      but_select_s <= ~stable_q[3:2];
      but_fire_s   <= ~stable_q[5:4];
      but_bomb_s   <= ~stable_q[7:6];
      but_tilt_s   <= {2{~stable_q[16]}};
      for (int p = 0; p < 2; p++) begin
        but_coin_s[p]  <= (coin_state_d[p] != C_PULSE);
        but_up_s[p]    <= (dir_d[p] != DIR_UP);
        but_down_s[p]  <= (dir_d[p] != DIR_DOWN);
        but_left_s[p]  <= (dir_d[p] != DIR_LEFT);
        but_right_s[p] <= (dir_d[p] != DIR_RIGHT);
      end
    end
  end

endmodule

// File: tb/tb_ladybug_input_cond.sv
// Directed bench for ladybug_input_cond with DEB_CYCLES=4, COIN_LEN=8, COIN_GAP=6.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ladybug_input_cond;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic [1:0] in_coin, in_start, in_fire, in_bomb;
  logic       in_tilt;
  logic [1:0] in_up, in_down, in_left, in_right;
  logic [1:0] but_coin_s, but_select_s, but_fire_s, but_bomb_s, but_tilt_s;
  logic [1:0] but_up_s, but_down_s, but_left_s, but_right_s;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  ladybug_input_cond #(
    .DEB_CYCLES(4),
    .COIN_LEN  (8),
    .COIN_GAP  (6)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .in_coin     (in_coin),
    .in_start    (in_start),
    .in_fire     (in_fire),
    .in_bomb     (in_bomb),
    .in_tilt     (in_tilt),
    .in_up       (in_up),
    .in_down     (in_down),
    .in_left     (in_left),
    .in_right    (in_right),
    .but_coin_s  (but_coin_s),
    .but_select_s(but_select_s),
    .but_fire_s  (but_fire_s),
    .but_bomb_s  (but_bomb_s),
    .but_tilt_s  (but_tilt_s),
    .but_up_s    (but_up_s),
    .but_down_s  (but_down_s),
    .but_left_s  (but_left_s),
    .but_right_s (but_right_s)
  );

  logic [17:0] all_out;
  logic [7:0]  dirs;
  assign all_out = {but_coin_s, but_select_s, but_fire_s, but_bomb_s, but_tilt_s,
                    but_up_s, but_down_s, but_left_s, but_right_s};
  assign dirs    = {but_up_s, but_down_s, but_left_s, but_right_s};

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    reset   = 1'b1;
    in_coin = '0; in_start = '0; in_fire = '0; in_bomb = '0; in_tilt = 1'b0;
    in_up   = '0; in_down  = '0; in_left = '0; in_right = '0;

    // Reset: three cycles, all outputs inactive during and after.
    tick(1);
    chk("reset_during", all_out, 18'h3FFFF);
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("reset_after", all_out, 18'h3FFFF);

    // Debounce: 3-cycle press, 1-cycle drop, then hold.
    in_fire[0] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      chk("fire_glitch_hi", {16'h0, but_fire_s}, {16'h0, 2'b11});
    end
    in_fire[0] = 1'b0;
    tick(1);
    chk("fire_glitch_lo", {16'h0, but_fire_s}, {16'h0, 2'b11});
    in_fire[0] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk("fire_press", {16'h0, but_fire_s}, {16'h0, (i < 5) ? 2'b11 : 2'b10});
    end
    in_fire[0] = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk("fire_release", {16'h0, but_fire_s}, {16'h0, (i < 5) ? 2'b10 : 2'b11});
    end

    // Coin: hold player-2 coin 40 cycles, one 8-cycle pulse only.
    in_coin[1] = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      chk("coin_hold", {16'h0, but_coin_s}, {16'h0, (i >= 5 && i <= 12) ? 2'b01 : 2'b11});
    end
    in_coin[1] = 1'b0;
    tick(6);
    chk("coin_released", all_out, 18'h3FFFF);

    // New pulse, then a re-press whose debounced edge lands in the gap.
    in_coin[1] = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      tick(1);
      chk("coin_gap_press", {16'h0, but_coin_s}, {16'h0, (j >= 5 && j <= 12) ? 2'b01 : 2'b11});
      in_coin[1] = !(j >= 6 && j <= 9);
    end
    in_coin[1] = 1'b0;
    tick(6);
    in_coin[1] = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      tick(1);
      chk("coin_after_gap", {16'h0, but_coin_s}, {16'h0, (j >= 5 && j <= 12) ? 2'b01 : 2'b11});
    end
    in_coin[1] = 1'b0;
    tick(6);

    // 4-way: up, then add right, release right, release up.
    in_up[0] = 1'b1;
    tick(5);
    chk("dir_up", {10'h0, dirs}, {10'h0, 8'b10_11_11_11});
    in_right[0] = 1'b1;
    tick(4);
    chk("dir_up_before_right", {10'h0, dirs}, {10'h0, 8'b10_11_11_11});
    tick(1);
    chk("dir_right_over_up", {10'h0, dirs}, {10'h0, 8'b11_11_11_10});
    in_right[0] = 1'b0;
    tick(4);
    chk("dir_right_held", {10'h0, dirs}, {10'h0, 8'b11_11_11_10});
    tick(1);
    chk("dir_back_to_up", {10'h0, dirs}, {10'h0, 8'b10_11_11_11});
    in_up[0] = 1'b0;
    tick(6);
    chk("dir_none", all_out, 18'h3FFFF);

    // Down and left together from NONE: down wins.
    in_down[0] = 1'b1;
    in_left[0] = 1'b1;
    tick(5);
    chk("dir_down_prio", {10'h0, dirs}, {10'h0, 8'b11_10_11_11});
    in_down[0] = 1'b0;
    in_left[0] = 1'b0;
    tick(6);
    chk("dir_none2", all_out, 18'h3FFFF);

    // Player-1 coin while player-2 holds left.
    in_coin[0] = 1'b1;
    in_left[1] = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      tick(1);
      chk("indep_coin", {16'h0, but_coin_s}, {16'h0, (j >= 5 && j <= 12) ? 2'b10 : 2'b11});
      chk("indep_dirs", {10'h0, dirs}, {10'h0, (j >= 5) ? 8'b11_11_01_11 : 8'hFF});
    end
    in_coin[0] = 1'b0;
    in_tilt    = 1'b1;
    tick(5);
    chk("tilt_on", {16'h0, but_tilt_s}, {16'h0, 2'b00});
    chk("tilt_dirs", {10'h0, dirs}, {10'h0, 8'b11_11_01_11});
    in_tilt    = 1'b0;
    in_left[1] = 1'b0;
    tick(6);
    chk("all_idle", all_out, 18'h3FFFF);

    // Reset on the third cycle of a pulse, coin held through and after reset.
    in_coin[0] = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      tick(1);
      chk("pre_reset_coin", {16'h0, but_coin_s}, {16'h0, (j >= 5) ? 2'b10 : 2'b11});
    end
    reset = 1'b1;
    tick(1);
    chk("mid_pulse_reset", all_out, 18'h3FFFF);
    tick(1);
    reset = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      chk("post_reset_coin", {16'h0, but_coin_s}, {16'h0, (k >= 5 && k <= 12) ? 2'b10 : 2'b11});
    end
    in_coin[0] = 1'b0;
    tick(6);
    chk("final_idle", all_out, 18'h3FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
